fp32_adder_unpiped: RTL and testbench
=====================================

// Module: fp32_adder_unpiped
// PURPOSE
//  Single-cycle (unpipelined) IEEE-754 binary32 adder/subtractor core.
//  Adds two single-precision operands: align, add/subtract, normalise, round.
//  The sum is captured in an output register.
//  Serves as the non-pipelined baseline against which the pipelined FP adder is compared.
// PARAMETERS
//  None (format fixed: 1 sign, 8 exponent bits (bias 127), 23 fraction bits).
// PORTS
//  clk81      in   1   single clock; all state updates on rising edge
//  reset_81   in   1   synchronous, active-high reset
//  a81        in   32  operand A, binary32
//  b81        in   32  operand B, binary32
//  result_81  out  32  registered binary32 sum a81+b81
// BEHAVIOUR
//  - Datapath: a81/b81 to packed sum is fully combinational.
//    result_81 <= sum at each rising clk81; no handshake, a new operand pair is accepted every cycle.
//  - Latency: 1 cycle. Operands stable before edge N appear on result_81 after edge N.
//  - Reset: reset_81=1 at a rising edge sets result_81 to 32'h0000_0000.
//    Reset has priority over the sum. Reset asserted mid-stream discards that cycle's sum.
//  - Unpack: hidden bit 1 for exp!=0; exp==0 operands (zero/denormal) are treated as signed zero (flush-to-zero).
//  - Swap: larger-magnitude operand (compare {exp,frac}) becomes the big one.
//    Result sign = sign of the big operand.
//  - Align: shift the small mantissa right by the exponent difference, keeping guard, round and sticky bits.
//    A difference >= 26 leaves sticky only.
//  - Add when signs are equal; otherwise subtract small from big.
//    A carry-out shifts right 1 and increments the exponent.
//  - Normalise after subtraction with a leading-zero count; left shift and decrement the exponent.
//  - Round to nearest, ties to even, using guard/round/sticky.
//    A rounding carry renormalises and increments the exponent.
//  - Exact cancellation (x + -x) gives +0. (+0)+(+0) = +0. (-0)+(-0) = -0. 0+x = x exactly.
//  - Overflow (exp >= 255 after rounding) gives signed infinity {s,8'hFF,23'h0}.
//  - Underflow (normalised exp <= 0) gives signed zero (no denormal output).
//  - Specials: NaN operand gives 32'h7FC0_0000. inf + -inf gives 32'h7FC0_0000.
//    inf + finite = that inf. inf + inf of the same sign = that inf.
//  - X/undefined inputs before first drive are don't-care; the output is defined after reset.
// TESTING
//  (Apply operands, check result_81 one rising edge later; 10 ns clock; pulse reset_81 first.)
//  - reset: reset_81=1 at an edge -> result_81=32'h00000000; deassert -> normal operation.
//  - same sign: 98+169 (42C40000,43290000) -> 43858000 (267).
//    -283+-66 (C38D8000,C2840000) -> C3AE8000 (-349).
//  - mixed sign: 99+-89 (42C60000,C2B20000) -> 41200000 (10).
//    -45+79 (C2340000,429E0000) -> 42080000 (34).
//  - fractions: -110.125+99.875 (C2DC4000,42C7C000) -> C1240000 (-10.25).
//    110.875+99.125 (42DDC000,42C64000) -> 43520000 (210).
//  - zeros: 0+0 -> 00000000; 0+-117 (00000000,C2EA0000) -> C2EA0000.
//    5+-5 (40A00000,C0A00000) -> 00000000.
//  - specials/rounding: 7F7FFFFF+7F7FFFFF -> 7F800000.
//    7F800000+FF800000 -> 7FC00000.
//    3F800000+33800000 (1+2^-24, tie) -> 3F800000.
//    3F800000+33800001 -> 3F800001.
//  - back-to-back: change operands every cycle -> each result appears exactly one edge later, no skipped/duplicated values.

Source files
------------

// File: rtl/fp32_adder_unpiped.sv
// Single-cycle IEEE-754 binary32 adder with a registered result.
// Denormal operands flush to zero, and results that would be denormal flush to signed zero.
module fp32_adder_unpiped (
  input  logic        clk81,
  input  logic        reset_81,
  input  logic [31:0] a81,
  input  logic [31:0] b81,
  output logic [31:0] result_81
);

  logic [31:0] result_d, result_q;

  logic        a_nan, b_nan, a_inf, b_inf;
  logic [30:0] mag_a, mag_b, mag_big, mag_small;
  logic        swap, sign_big, eff_sub;
  logic [7:0]  exp_big, exp_small, diff;
  logic [23:0] m_big, m_small;
  logic [49:0] wide;
  logic [26:0] big_al, small_al, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  exp_n, exp_r;
  logic        round_up;
  logic [24:0] mant_r;
  logic [22:0] frac_r;

  always_comb begin
    a_nan = (a81[30:23] == 8'hFF) && (a81[22:0] != 23'h0);
    b_nan = (b81[30:23] == 8'hFF) && (b81[22:0] != 23'h0);
    a_inf = (a81[30:23] == 8'hFF) && (a81[22:0] == 23'h0);
    b_inf = (b81[30:23] == 8'hFF) && (b81[22:0] == 23'h0);

    // Zero exponent means zero or denormal; both are treated as zero.
    mag_a = (a81[30:23] == 8'h00) ? 31'h0 : a81[30:0];
    mag_b = (b81[30:23] == 8'h00) ? 31'h0 : b81[30:0];

    swap      = mag_b > mag_a;
    mag_big   = swap ? mag_b : mag_a;
    mag_small = swap ? mag_a : mag_b;
    sign_big  = swap ? b81[31] : a81[31];
    eff_sub   = a81[31] ^ b81[31];

    exp_big   = mag_big[30:23];
    exp_small = mag_small[30:23];
    m_big     = {exp_big != 8'h00, mag_big[22:0]};
    m_small   = {exp_small != 8'h00, mag_small[22:0]};
    diff      = exp_big - exp_small;

    // Aligned layout: {mantissa[23:0], guard, round, sticky}.
    wide = '0;
    if (diff >= 8'd26) begin
      small_al = {26'h0, |m_small};
    end else begin
      wide     = {m_small, 26'h0} >> diff;
      small_al = {wide[49:24], |wide[23:0]};
    end
    big_al = {m_big, 3'b000};

    sum = eff_sub ? ({1'b0, big_al} - {1'b0, small_al})
                  : ({1'b0, big_al} + {1'b0, small_al});

    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, exp_big} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = {2'b00, exp_big} - {5'b00000, lz};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'h0, round_up};
    exp_r    = exp_n + {9'h0, mant_r[24]};
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      result_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      result_d = a81;
    end else if (b_inf) begin
      result_d = b81;
    end else if (sum == 28'h0) begin
      // Cancellation yields +0; only like-signed zeros keep their sign.
      result_d = {sign_big & ~eff_sub, 31'h0};
    end else if (exp_n[9] || (exp_n == 10'h0)) begin
      result_d = {sign_big, 31'h0};
    end else if (exp_r >= 10'd255) begin
      result_d = {sign_big, 8'hFF, 23'h0};
    end else begin
      result_d = {sign_big, exp_r[7:0], frac_r};
    end
  end

  always_ff @(posedge clk81) begin
    if (reset_81) result_q <= 32'h0000_0000;
    else          result_q <= result_d;
  end

  assign result_81 = result_q;

endmodule

// File: tb/tb_fp32_adder_unpiped.sv
// Bench for fp32_adder_unpiped: directed spec vectors plus random operands checked
// against a reference built on double-precision arithmetic.
module tb_fp32_adder_unpiped;

  logic        clk81;
  logic        reset_81;
  logic [31:0] a81, b81;
  logic [31:0] result_81;

  int checks;
  int failures;

  fp32_adder_unpiped dut (
    .clk81     (clk81),
    .reset_81  (reset_81),
    .a81       (a81),
    .b81       (b81),
    .result_81 (result_81)
  );

  initial clk81 = 1'b0;
  always #5 clk81 = ~clk81;

  // binary32 -> binary64 bit pattern, flushing denormals to signed zero.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h00) return {f[31], 63'h0};
    e = 11'(int'(f[30:23]) - 127 + 1023);
    return {f[31], e, f[22:0], 29'h0};
  endfunction

  // Round a binary64 to binary32 (nearest-even), flushing tiny results to zero.
  function automatic logic [31:0] d2f(input logic [63:0] d);
    int          fe;
    logic [52:0] mant;
    logic [23:0] keep;
    logic [28:0] rest;
    logic        up;
    logic [24:0] k25;
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    fe = int'(d[62:52]) - 1023 + 127;
    if (fe <= 0) return {d[63], 31'h0};
    mant = {1'b1, d[51:0]};
    keep = mant[52:29];
    rest = mant[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0]);
    k25  = {1'b0, keep} + {24'h0, up};
    if (k25[24]) fe = fe + 1;
    if (fe >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], 8'(fe), k25[24] ? 23'h0 : k25[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    real  s;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    s = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
    return d2f($realtobits(s));
  endfunction

  function automatic int clamp_exp(input int e);
    if (e < 1) return 1;
    if (e > 254) return 254;
    return e;
  endfunction

  function automatic int pick_centre();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(1, 5));
      1:       return int'($urandom_range(250, 254));
      2:       return int'($urandom_range(100, 150));
      default: return int'($urandom_range(1, 254));
    endcase
  endfunction

  function automatic logic [31:0] gen(input int centre);
    int          sel, e;
    logic [22:0] frac;
    sel  = int'($urandom_range(0, 15));
    frac = 23'($urandom);
    if (sel == 0)      e = 0;
    else if (sel == 1) begin
      e = 255;
      if ($urandom_range(0, 1) == 0) frac = 23'h0;
    end
    else if (sel < 8)  e = clamp_exp(centre + int'($urandom_range(0, 6)) - 3);
    else if (sel < 12) e = clamp_exp(centre + int'($urandom_range(0, 60)) - 30);
    else               e = int'($urandom_range(1, 254));
    return {1'($urandom), 8'(e), frac};
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input string tag);
    a81 = a;
    b81 = b;
    @(posedge clk81);
    #1;
    checks++;
    assert (result_81 === expv) else begin
      failures++;
      $error("FAIL %s a=%h b=%h got=%h exp=%h", tag, a, b, result_81, expv);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          centre;
    checks   = 0;
    failures = 0;
    reset_81 = 1'b1;
    a81      = 32'h42C4_0000;
    b81      = 32'h4329_0000;
    @(posedge clk81);
    @(posedge clk81);
    #1;
    checks++;
    assert (result_81 === 32'h0) else begin
      failures++;
      $error("FAIL reset got=%h exp=%h", result_81, 32'h0);
    end
    reset_81 = 1'b0;

    step(32'h42C4_0000, 32'h4329_0000, 32'h4385_8000, "same_pos");
    step(32'hC38D_8000, 32'hC284_0000, 32'hC3AE_8000, "same_neg");
    step(32'h42C6_0000, 32'hC2B2_0000, 32'h4120_0000, "mixed_a");
    step(32'hC234_0000, 32'h429E_0000, 32'h4208_0000, "mixed_b");
    step(32'hC2DC_4000, 32'h42C7_C000, 32'hC124_0000, "frac_a");
    step(32'h42DD_C000, 32'h42C6_4000, 32'h4352_0000, "frac_b");
    step(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_zero");
    step(32'h0000_0000, 32'hC2EA_0000, 32'hC2EA_0000, "zero_x");
    step(32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000, "cancel");
    step(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "negzero");
    step(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow");
    step(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    step(32'h7F80_0000, 32'h4120_0000, 32'h7F80_0000, "inf_finite");
    step(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, "ninf_ninf");
    step(32'h7FA0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan");
    step(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "tie_even");
    step(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "round_up");
    step(32'h0100_0001, 32'h8100_0000, 32'h0000_0000, "underflow");
    step(32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, "denorm_ftz");

    // Reset mid-stream discards the sum presented at that edge.
    reset_81 = 1'b1;
    step(32'h42C4_0000, 32'h4329_0000, 32'h0000_0000, "reset_mid");
    reset_81 = 1'b0;
    step(32'h42C6_0000, 32'hC2B2_0000, 32'h4120_0000, "after_reset");

    for (int n = 0; n < 3000; n++) begin
      centre = pick_centre();
      ra     = gen(centre);
      case ($urandom_range(0, 7))
        0:       rb = {~ra[31], ra[30:0]};
        1:       rb = {~ra[31], ra[30:8], 8'($urandom)};
        default: rb = gen(centre);
      endcase
      step(ra, rb, ref_add(ra, rb), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
